pack_arbiter: RTL and testbench

- Shares the single packet-sender downward interface (PacketAvail / PacketNext / PacketNextWd / PacketIn) between NUM_SRC independent 16-bit packet sources, e.g. several trace capture channels.
- Grants whole packets in round-robin order among enabled sources, and routes word strobes and data to and from the granted source.
- Suppresses packet offers while the link is out of sync.
- Keeps per-source packet counters for diagnostics.

---
 rtl/pack_arbiter_pkg.sv | 28 ++
 rtl/pack_arbiter_if.sv | 28 ++
 rtl/rr_select.sv | 20 ++
 rtl/pack_arbiter.sv | 126 ++++++++++++
 tb/tb_pack_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pack_arbiter_pkg.sv
// Shared constants and the round-robin pick helper for packet arbiters.
package pack_arb_pkg;

  localparam int MAX_SRC   = 4;
  localparam int SRC_IDX_W = 2;
  localparam int WORD_W    = 16;

  // Returns {valid, index} of the first set req bit at or above ptr, wrapping.
  // Unused upper req bits must be zero, so wrapping modulo MAX_SRC visits the
  // live sources in the same order as wrapping modulo the real source count.
  function automatic logic [SRC_IDX_W:0] rr_pick(input logic [MAX_SRC-1:0]   req,
                                                 input logic [SRC_IDX_W-1:0] ptr);
    logic                 found;
    logic [SRC_IDX_W-1:0] idx;
    logic [SRC_IDX_W-1:0] probe;
    found = 1'b0;
    idx   = {SRC_IDX_W{1'b0}};
    for (int k = 0; k < MAX_SRC; k++) begin
      probe = ptr + SRC_IDX_W'(k);
      if (!found && req[probe]) begin
        found = 1'b1;
        idx   = probe;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/pack_arbiter_if.sv
// Source-side and sender-side handshake bundle of the packet arbiter.
interface pack_arbiter_if #(
  parameter int NUM_SRC = 2
);
  import pack_arb_pkg::*;

  logic                        sync;
  logic [NUM_SRC-1:0]          SrcAvail;
  logic [NUM_SRC-1:0]          SrcNext;
  logic [NUM_SRC-1:0]          SrcNextWd;
  logic [WORD_W*NUM_SRC-1:0]   SrcData;
  logic [NUM_SRC-1:0]          EnMask;
  logic                        PacketAvail;
  logic                        PacketNext;
  logic                        PacketNextWd;
  logic [WORD_W-1:0]           PacketIn;

  modport master (
    output sync, SrcAvail, SrcData, EnMask, PacketNext, PacketNextWd,
    input  SrcNext, SrcNextWd, PacketAvail, PacketIn
  );

  modport slave (
    input  sync, SrcAvail, SrcData, EnMask, PacketNext, PacketNextWd,
    output SrcNext, SrcNextWd, PacketAvail, PacketIn
  );

endinterface

// File: rtl/rr_select.sv
// Combinational round-robin priority picker, generic in the source count.
module rr_select
  import pack_arb_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic               valid,
  output logic [SRC_W-1:0]   idx
);

  logic [SRC_IDX_W:0] pick_s;

  assign pick_s = rr_pick(MAX_SRC'(req), SRC_IDX_W'(ptr));
  assign valid  = pick_s[SRC_IDX_W];
  assign idx    = SRC_W'(pick_s[SRC_IDX_W-1:0]);

endmodule

// File: rtl/pack_arbiter.sv
// Shares one packet-sender link between NUM_SRC sources with whole-packet
// round-robin grants and per-source packet counters.
module pack_arbiter
  import pack_arb_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int SRC_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  pack_arbiter_if.slave      bus,
  output logic [SRC_W-1:0]   GrantId,
  output logic               GrantValid,
  input  logic               CntClear,
  input  logic [SRC_W-1:0]   CntSel,
  output logic [CNT_W-1:0]   CntVal
);

  logic [NUM_SRC-1:0] req_s;
  logic               candValid_s;
  logic [SRC_W-1:0]   cand_s;
  logic               packetAvail_s;
  logic               grantEvt_s;
  logic               wordLive_s;
  logic [SRC_W-1:0]   wordIdx_s;
  logic [SRC_W-1:0]   nextPtr_s;
  logic [NUM_SRC-1:0] srcNext_s;
  logic [NUM_SRC-1:0] srcNextWd_s;
  logic [WORD_W-1:0]  packetIn_s;
  logic [CNT_W-1:0]   selCnt_s;

  logic [SRC_W-1:0]   grantId_r;
  logic [SRC_W-1:0]   rrPtr_r;
  logic               grantValid_r;
  logic [CNT_W-1:0]   cnt_r [NUM_SRC];
  logic [CNT_W-1:0]   cntVal_r;

  assign req_s = bus.SrcAvail & bus.EnMask;

  rr_select #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) uSelect (
    .req   (req_s),
    .ptr   (rrPtr_r),
    .valid (candValid_s),
    .idx   (cand_s)
  );

  assign packetAvail_s = candValid_s & bus.sync & rst;
  assign grantEvt_s    = bus.PacketNext & packetAvail_s;
  // The sender's first word strobe may coincide with the packet accept.
  assign wordIdx_s     = grantEvt_s ? cand_s : grantId_r;
  assign wordLive_s    = (grantEvt_s | grantValid_r) & rst;
  assign nextPtr_s     = (cand_s == SRC_W'(NUM_SRC - 1)) ? {SRC_W{1'b0}}
                                                         : cand_s + SRC_W'(1);

  // Route packet/word strobes and the data word to and from one source.
  always_comb begin
    srcNext_s   = {NUM_SRC{1'b0}};
    srcNextWd_s = {NUM_SRC{1'b0}};
    packetIn_s  = {WORD_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grantEvt_s && (cand_s == SRC_W'(i))) begin
        srcNext_s[i] = 1'b1;
      end else begin
        srcNext_s[i] = 1'b0;
      end
      if (wordLive_s && (wordIdx_s == SRC_W'(i))) begin
        srcNextWd_s[i] = bus.PacketNextWd;
        packetIn_s     = bus.SrcData[WORD_W*i +: WORD_W];
      end else begin
        srcNextWd_s[i] = 1'b0;
      end
    end
  end

  // Counter read mux; out-of-range selects read as zero.
  always_comb begin
    selCnt_s = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (CntSel == SRC_W'(i)) begin
        selCnt_s = cnt_r[i];
      end else begin
        selCnt_s = selCnt_s;
      end
    end
  end

  // Grant ownership, round-robin pointer, packet counters and counter readout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      grantId_r    <= {SRC_W{1'b0}};
      grantValid_r <= 1'b0;
      rrPtr_r      <= {SRC_W{1'b0}};
      cntVal_r     <= {CNT_W{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      if (grantEvt_s) begin
        grantId_r    <= cand_s;
        grantValid_r <= 1'b1;
        rrPtr_r      <= nextPtr_s;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (CntClear) begin
          cnt_r[i] <= {CNT_W{1'b0}};
        end else if (grantEvt_s && (cand_s == SRC_W'(i))) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
      cntVal_r <= selCnt_s;
    end
  end

  assign bus.PacketAvail = packetAvail_s;
  assign bus.SrcNext     = srcNext_s;
  assign bus.SrcNextWd   = srcNextWd_s;
  assign bus.PacketIn    = packetIn_s;
  assign GrantId         = grantId_r;
  assign GrantValid      = grantValid_r;
  assign CntVal          = cntVal_r;

endmodule

// File: tb/tb_pack_arbiter.sv
// Self-checking bench for pack_arbiter: directed scenarios plus randomized
// traffic against a behavioural model of the arbitration rules.
`timescale 1ns/1ps
module tb_pack_arbiter;
  import pack_arb_pkg::*;

  localparam int NUM_SRC = 2;
  localparam int SRC_W   = 2;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [SRC_W-1:0] GrantId;
  logic             GrantValid;
  logic             CntClear;
  logic [SRC_W-1:0] CntSel;
  logic [CNT_W-1:0] CntVal;

  int checks = 0;
  int errors = 0;

  pack_arbiter_if #(.NUM_SRC(NUM_SRC)) bus ();

  pack_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .GrantId    (GrantId),
    .GrantValid (GrantValid),
    .CntClear   (CntClear),
    .CntSel     (CntSel),
    .CntVal     (CntVal)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int   mPtr = 0;
  int   mGid = 0;
  bit   mGv  = 1'b0;
  int   mCnt [NUM_SRC];
  int   mCntVal = 0;
  logic               eAvail;
  logic [NUM_SRC-1:0] eNext;
  logic [NUM_SRC-1:0] eNextWd;
  logic [15:0]        eIn;

  function automatic int model_cand();
    int s;
    for (int k = 0; k < NUM_SRC; k++) begin
      s = (mPtr + k) % NUM_SRC;
      if (bus.SrcAvail[s] === 1'b1 && bus.EnMask[s] === 1'b1) return s;
    end
    return -1;
  endfunction

  task automatic model_comb();
    int c;
    int w;
    c = model_cand();
    eAvail  = (rst === 1'b1) && (bus.sync === 1'b1) && (c >= 0);
    eNext   = '0;
    eNextWd = '0;
    eIn     = 16'h0000;
    w = -1;
    if (eAvail && bus.PacketNext === 1'b1) begin
      eNext[c] = 1'b1;
      w = c;
    end else if (mGv) begin
      w = mGid;
    end
    if (rst === 1'b1 && w >= 0) begin
      eNextWd[w] = bus.PacketNextWd;
      eIn        = bus.SrcData[w*16 +: 16];
    end
  endtask

  task automatic model_edge();
    int c;
    bit g;
    model_comb();
    c = model_cand();
    g = eAvail && (bus.PacketNext === 1'b1);
    if (rst !== 1'b1) begin
      mPtr = 0; mGid = 0; mGv = 1'b0; mCntVal = 0;
      for (int i = 0; i < NUM_SRC; i++) mCnt[i] = 0;
    end else begin
      mCntVal = (int'(CntSel) < NUM_SRC) ? mCnt[CntSel] : 0;
      if (g) begin
        mGid = c; mGv = 1'b1; mPtr = (c + 1) % NUM_SRC;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (CntClear === 1'b1) mCnt[i] = 0;
        else if (g && c == i) mCnt[i] = (mCnt[i] + 1) % (1 << CNT_W);
      end
    end
  endtask

  task automatic advance();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.sync = 1'b1; bus.SrcAvail = 2'b11; bus.EnMask = 2'b11;
    bus.PacketNext = 1'b1; bus.PacketNextWd = 1'b1; bus.SrcData = 32'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.PacketAvail, bus.SrcNext, bus.SrcNextWd, bus.PacketIn} !== 21'd0) begin
        errors++;
        $display("FAIL reset_comb avail=%b next=%b nextwd=%b in=%h required all zero",
                 bus.PacketAvail, bus.SrcNext, bus.SrcNextWd, bus.PacketIn);
      end
      advance();
      checks++;
      if (GrantValid !== 1'b0 || GrantId !== 2'd0 || CntVal !== 8'd0) begin
        errors++;
        $display("FAIL reset_regs gv=%b gid=%0d cnt=%0d required 0/0/0", GrantValid, GrantId, CntVal);
      end
    end
    bus.PacketNext = 1'b0; bus.PacketNextWd = 1'b0; rst = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [1:0] expNext;
    bus.SrcAvail = 2'b11; bus.EnMask = 2'b11; bus.sync = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expNext = 2'b01 << (i % 2);
      bus.PacketNext = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.SrcNext !== expNext) begin
        errors++;
        $display("FAIL rr_srcnext got=%b required=%b", bus.SrcNext, expNext);
      end
      advance();
      checks++;
      if (GrantId !== SRC_W'(i % 2) || GrantValid !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant got=%0d/%b required=%0d/1", GrantId, GrantValid, i % 2);
      end
      bus.PacketNext = 1'b0;
      advance();
    end
    for (int s = 0; s < 4; s++) begin
      CntSel = SRC_W'(s);
      advance();
      checks++;
      if (CntVal !== ((s < 2) ? 8'd2 : 8'd0)) begin
        errors++;
        $display("FAIL rr_count sel=%0d got=%0d required=%0d", s, CntVal, (s < 2) ? 2 : 0);
      end
    end
  endtask

  task automatic test_word_path();
    int pulses1 = 0;
    int pulses0 = 0;
    bus.SrcData = {16'hA55A, 16'h1234}; bus.SrcAvail = 2'b10; bus.PacketNext = 1'b1;
    advance();
    bus.PacketNext = 1'b0; bus.SrcAvail = 2'b01; bus.EnMask = 2'b01;
    for (int i = 0; i < 8; i++) begin
      bus.PacketNextWd = 1'b1;
      @(negedge clk);
      pulses1 += int'(bus.SrcNextWd[1]);
      pulses0 += int'(bus.SrcNextWd[0]);
      checks++;
      if (bus.PacketIn !== 16'hA55A || bus.SrcNextWd !== 2'b10) begin
        errors++;
        $display("FAIL word_path in=%h nextwd=%b required A55A/10", bus.PacketIn, bus.SrcNextWd);
      end
      advance();
      bus.PacketNextWd = 1'b0;
      advance();
    end
    checks++;
    if (pulses1 != 8 || pulses0 != 0) begin
      errors++;
      $display("FAIL word_pulses src1=%0d src0=%0d required 8/0", pulses1, pulses0);
    end
    bus.EnMask = 2'b11;
  endtask

  task automatic test_enmask();
    bus.EnMask = 2'b01; bus.SrcAvail = 2'b11;
    for (int i = 0; i < 3; i++) begin
      bus.PacketNext = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.SrcNext !== 2'b01) begin
        errors++;
        $display("FAIL enmask_srcnext got=%b required=01", bus.SrcNext);
      end
      advance();
      bus.PacketNext = 1'b0;
      advance();
    end
    CntSel = 2'd0; advance();
    checks++;
    if (CntVal !== 8'd5) begin
      errors++;
      $display("FAIL enmask_cnt0 got=%0d required=5", CntVal);
    end
    CntSel = 2'd1; advance();
    checks++;
    if (CntVal !== 8'd3) begin
      errors++;
      $display("FAIL enmask_cnt1 got=%0d required=3", CntVal);
    end
    bus.EnMask = 2'b11;
  endtask

  task automatic test_sync();
    rst = 1'b0; advance(); rst = 1'b1;
    bus.sync = 1'b0; bus.SrcAvail = 2'b01; bus.PacketNext = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.PacketAvail !== 1'b0 || bus.SrcNext !== 2'b00) begin
      errors++;
      $display("FAIL sync_block avail=%b next=%b required 0/00", bus.PacketAvail, bus.SrcNext);
    end
    advance();
    checks++;
    if (GrantValid !== 1'b0) begin
      errors++;
      $display("FAIL sync_nogrant gv=%b required=0", GrantValid);
    end
    bus.sync = 1'b1; bus.PacketNext = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.PacketAvail !== 1'b1) begin
      errors++;
      $display("FAIL sync_resume avail=%b required=1", bus.PacketAvail);
    end
    bus.PacketNext = 1'b1; advance();
    bus.PacketNext = 1'b0; bus.sync = 1'b0; bus.PacketNextWd = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.SrcNextWd !== 2'b01 || bus.PacketAvail !== 1'b0) begin
      errors++;
      $display("FAIL sync_inflight nextwd=%b avail=%b required 01/0", bus.SrcNextWd, bus.PacketAvail);
    end
    advance();
    bus.PacketNextWd = 1'b0; bus.sync = 1'b1;
  endtask

  task automatic test_same_cycle();
    bus.SrcAvail = 2'b11; bus.EnMask = 2'b11; bus.SrcData = {16'hBEEF, 16'h0F0F};
    bus.PacketNext = 1'b1; bus.PacketNextWd = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.SrcNext !== 2'b10 || bus.SrcNextWd !== 2'b10 || bus.PacketIn !== 16'hBEEF) begin
      errors++;
      $display("FAIL same_cycle next=%b nextwd=%b in=%h required 10/10/BEEF",
               bus.SrcNext, bus.SrcNextWd, bus.PacketIn);
    end
    advance();
    bus.PacketNext = 1'b0; bus.PacketNextWd = 1'b0;
    checks++;
    if (GrantId !== 2'd1) begin
      errors++;
      $display("FAIL same_cycle_gid got=%0d required=1", GrantId);
    end
  endtask

  task automatic test_counter_wrap();
    CntClear = 1'b1; advance(); CntClear = 1'b0;
    bus.EnMask = 2'b01; bus.SrcAvail = 2'b01; bus.PacketNext = 1'b1;
    for (int i = 0; i < 255; i++) advance();
    bus.PacketNext = 1'b0; CntSel = 2'd0; advance();
    checks++;
    if (CntVal !== 8'hFF) begin
      errors++;
      $display("FAIL cnt_full got=%h required=ff", CntVal);
    end
    bus.PacketNext = 1'b1; advance(); bus.PacketNext = 1'b0; advance();
    checks++;
    if (CntVal !== 8'h00) begin
      errors++;
      $display("FAIL cnt_wrap got=%h required=00", CntVal);
    end
    bus.PacketNext = 1'b1; advance();
    CntClear = 1'b1; advance();
    CntClear = 1'b0; bus.PacketNext = 1'b0;
    for (int s = 0; s < 2; s++) begin
      CntSel = SRC_W'(s); advance();
      checks++;
      if (CntVal !== 8'h00) begin
        errors++;
        $display("FAIL cnt_clear sel=%0d got=%h required=00", s, CntVal);
      end
    end
    bus.EnMask = 2'b11;
  endtask

  task automatic test_reset_mid_packet();
    bus.SrcAvail = 2'b10; bus.SrcData = {16'hC3C3, 16'h5A5A}; bus.PacketNext = 1'b1;
    advance();
    bus.PacketNext = 1'b0; bus.PacketNextWd = 1'b1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.SrcNextWd !== 2'b00 || bus.PacketIn !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_during nextwd=%b in=%h required 00/0000", bus.SrcNextWd, bus.PacketIn);
    end
    advance();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (GrantValid !== 1'b0 || bus.SrcNextWd !== 2'b00 || bus.PacketIn !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_after gv=%b nextwd=%b in=%h required 0/00/0000",
               GrantValid, bus.SrcNextWd, bus.PacketIn);
    end
    advance();
    bus.PacketNextWd = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      rst              = ($urandom_range(0, 39) != 0);
      bus.sync         = ($urandom_range(0, 5) != 0);
      bus.SrcAvail     = NUM_SRC'($urandom);
      bus.EnMask       = NUM_SRC'($urandom);
      bus.SrcData      = 32'($urandom);
      bus.PacketNext   = ($urandom_range(0, 2) == 0);
      bus.PacketNextWd = 1'($urandom);
      CntClear         = ($urandom_range(0, 49) == 0);
      CntSel           = SRC_W'($urandom);
      @(negedge clk);
      model_comb();
      checks++;
      if (bus.PacketAvail !== eAvail || bus.SrcNext !== eNext ||
          bus.SrcNextWd !== eNextWd || bus.PacketIn !== eIn) begin
        errors++;
        $display("FAIL rand_comb n=%0d avail=%b/%b next=%b/%b nextwd=%b/%b in=%h/%h (got/required)",
                 n, bus.PacketAvail, eAvail, bus.SrcNext, eNext, bus.SrcNextWd, eNextWd, bus.PacketIn, eIn);
      end
      checks++;
      if (!$onehot0(bus.SrcNext) || !$onehot0(bus.SrcNextWd)) begin
        errors++;
        $display("FAIL rand_onehot next=%b nextwd=%b required one-hot or zero", bus.SrcNext, bus.SrcNextWd);
      end
      advance();
      checks++;
      if (GrantId !== SRC_W'(mGid) || GrantValid !== mGv || CntVal !== CNT_W'(mCntVal)) begin
        errors++;
        $display("FAIL rand_regs n=%0d gid=%0d/%0d gv=%b/%b cnt=%0d/%0d (got/required)",
                 n, GrantId, mGid, GrantValid, mGv, CntVal, mCntVal);
      end
    end
  endtask

  initial begin
    rst = 1'b0; bus.sync = 1'b1; bus.SrcAvail = '0; bus.EnMask = '0; bus.SrcData = '0;
    bus.PacketNext = 1'b0; bus.PacketNextWd = 1'b0; CntClear = 1'b0; CntSel = '0;
    for (int i = 0; i < NUM_SRC; i++) mCnt[i] = 0;
    test_reset();
    test_round_robin();
    test_word_path();
    test_enmask();
    test_sync();
    test_same_cycle();
    test_counter_wrap();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
